// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared constants, output-word layout and drain state enum for md_readback
package md_pkg;

  localparam int D_W             = 192;
  localparam int OUT_W           = 256;
  localparam int STEP_LSB        = 224;
  localparam int IDX_LSB         = 192;
  localparam int N_PARTICLES_DEF = 300;
  localparam int TIMEOUT_DEF     = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GAP,
    ST_DRAIN,
    ST_ERR
  } rb_state_t;

  // Output word: step in [255:224], zero pad, idx in [207:192], core record below.
  function automatic logic [OUT_W-1:0] pack_word(input logic [31:0]    step,
                                                 input logic [15:0]    idx,
                                                 input logic [D_W-1:0] rec);
    pack_word = {step, 16'd0, idx, rec};
  endfunction

endpackage

// File: rtl/md_readback_if.sv
// rtl/md_readback_if.sv - host-bound record stream (valid/ready with last marker)
interface md_readback_if;
  import md_pkg::*;

  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/md_rb_fifo.sv
// rtl/md_rb_fifo.sv - 2-entry record FIFO; head entry is a register driven straight to the stream
module md_rb_fifo
  import md_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [OUT_W-1:0] push_data,
  input  logic             pop,
  output logic [OUT_W-1:0] head,
  output logic [1:0]       count
);

  logic [OUT_W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Pop and push together: the new record lands behind whatever remains.
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/md_readback.sv
// rtl/md_readback.sv - drains per-particle records from the MD core into a tagged 256-bit stream
module md_readback
  import md_pkg::*;
#(
  parameter int N_PARTICLES = N_PARTICLES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           start,
  input  logic [31:0]    step_in,
  output logic           read_ctrl,
  input  logic           elem_read,
  input  logic [D_W-1:0] md_d_out,
  md_readback_if.master  m,
  output logic           busy,
  output logic           done,
  output logic           timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  rb_state_t        state, state_n;
  logic [31:0]      step;
  logic [15:0]      idx;
  logic [TW-1:0]    timer;
  logic [OUT_W-1:0] head;
  logic [1:0]       count;
  logic             accept_start, push, pop, tvalid, tlast;

  assign accept_start = start && (state == ST_IDLE || state == ST_ERR);
  assign push         = (state == ST_REQ) && elem_read;
  assign tvalid       = (count != 2'd0);
  assign tlast        = tvalid && (head[IDX_LSB +: 16] == 16'(N_PARTICLES - 1));
  assign pop          = tvalid && m.m_tready;

  assign m.m_tdata  = head;
  assign m.m_tvalid = tvalid;
  assign m.m_tlast  = tlast;
  assign read_ctrl  = (state == ST_REQ);
  assign busy       = (state != ST_IDLE);

  md_rb_fifo u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .flush     (accept_start),
    .push      (push),
    .push_data (pack_word(step, idx, md_d_out)),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (accept_start) state_n = ST_REQ;
      // A capture on the final timer cycle takes priority over the timeout.
      ST_REQ: begin
        if (push)                             state_n = ST_GAP;
        else if (timer == TW'(TIMEOUT - 1))   state_n = ST_ERR;
      end
      ST_GAP: begin
        if (idx == 16'(N_PARTICLES))          state_n = ST_DRAIN;
        else if (count < 2'd2)                state_n = ST_REQ;
      end
      ST_DRAIN: if (count == 2'd0 || (count == 2'd1 && pop)) state_n = ST_IDLE;
      ST_ERR:   if (accept_start) state_n = ST_REQ;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= ST_IDLE;
      step        <= '0;
      idx         <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_n;
      done  <= pop && tlast;
      if (accept_start) begin
        step        <= step_in;
        idx         <= '0;
        timer       <= '0;
        timeout_err <= 1'b0;
      end else begin
        timer <= (state == ST_REQ) ? timer + TW'(1) : '0;
        if (push) idx <= idx + 16'd1;
        if (state == ST_REQ && state_n == ST_ERR) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_readback.sv
// tb/tb_md_readback.sv - directed bench for md_readback with N_PARTICLES=4, TIMEOUT=16
module tb_md_readback;

  localparam int NP = 4;
  localparam int TO = 16;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  step_in = '0;
  logic         elem_read = 1'b0;
  logic [191:0] md_d_out = '0;
  logic         read_ctrl, busy, done, timeout_err;

  md_readback_if mif ();

  md_readback #(.N_PARTICLES(NP), .TIMEOUT(TO)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .start       (start),
    .step_in     (step_in),
    .read_ctrl   (read_ctrl),
    .elem_read   (elem_read),
    .md_d_out    (md_d_out),
    .m           (mif.master),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad = 0;

  logic [255:0] rx_q[$];
  logic         rxl_q[$];
  int           done_cnt = 0;

  bit resp_on = 1'b0;
  bit spur = 1'b0;
  bit err_seen = 1'b0;
  int resp_dly = 2;
  int rc_age = 0;
  int serve = 0;
  int caps = 0;

  always @(posedge ap_clk) begin
    if (ap_rst_n) begin
      if (mif.m_tvalid && mif.m_tready) begin
        rx_q.push_back(mif.m_tdata);
        rxl_q.push_back(mif.m_tlast);
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [191:0] rec(int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + i;
    rec = {6{w}};
  endfunction

  function automatic logic [255:0] expw(logic [31:0] s, int i);
    logic [15:0] ix;
    ix = i[15:0];
    expw = {s, 16'h0000, ix, rec(i)};
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock; afterwards the core model reacts to the freshly updated read_ctrl.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    elem_read = 1'b0;
    md_d_out  = {6{32'hDEAD_BEEF}};
    if (read_ctrl === 1'b1) begin
      if (resp_on) begin
        rc_age++;
        if (rc_age >= resp_dly) begin
          elem_read = 1'b1;
          md_d_out  = rec(serve);
          serve++;
          caps++;
          rc_age = 0;
        end
      end
    end else begin
      rc_age = 0;
      if (spur) elem_read = 1'b1;
    end
    if (timeout_err === 1'b1) err_seen = 1'b1;
  endtask

  task automatic pulse_start(logic [31:0] s);
    start   = 1'b1;
    step_in = s;
    tick();
    start   = 1'b0;
    step_in = 32'h0;
  endtask

  task automatic wait_done(int base, string tag);
    int n;
    n = 0;
    while (done_cnt == base && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt != base, 1'b1);
    repeat (3) tick();
    chk({tag, "_done_once"}, done_cnt - base, 1);
  endtask

  task automatic check_words(int rbase, logic [31:0] s, string tag);
    chk({tag, "_nwords"}, rx_q.size() - rbase, NP);
    for (int i = 0; i < NP; i++) begin
      if (rbase + i < rx_q.size()) begin
        chk({tag, "_word"}, rx_q[rbase + i], expw(s, i));
        chk({tag, "_tlast"}, rxl_q[rbase + i], (i == NP - 1));
      end
    end
  endtask

  initial begin
    int rb, db, n;
    mif.m_tready = 1'b0;

    repeat (3) tick();
    chk("rst_read_ctrl", read_ctrl, 1'b0);
    chk("rst_tvalid", mif.m_tvalid, 1'b0);
    chk("rst_tlast", mif.m_tlast, 1'b0);
    chk("rst_tdata", mif.m_tdata, 256'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    ap_rst_n = 1'b1;
    tick();

    // Normal drain, core answers two cycles into each request.
    mif.m_tready = 1'b1;
    resp_on = 1'b1; resp_dly = 2; serve = 0;
    chk("idle_read_ctrl", read_ctrl, 1'b0);
    rb = rx_q.size(); db = done_cnt;
    pulse_start(32'd7);
    chk("norm_rc_rise", read_ctrl, 1'b1);
    chk("norm_busy", busy, 1'b1);
    n = 0;
    while (elem_read !== 1'b1 && n < 10) begin tick(); n++; end
    tick();
    chk("norm_latency_tvalid", mif.m_tvalid, 1'b1);
    chk("norm_rc_fall", read_ctrl, 1'b0);
    chk("norm_first_tdata", mif.m_tdata, expw(32'd7, 0));
    wait_done(db, "norm");
    check_words(rb, 32'd7, "norm");
    chk("norm_idle_busy", busy, 1'b0);

    // Backpressure: two captures fill the FIFO, then requests stop.
    mif.m_tready = 1'b0;
    serve = 0; caps = 0;
    rb = rx_q.size(); db = done_cnt;
    pulse_start(32'd9);
    repeat (20) tick();
    chk("bp_caps", caps, 2);
    chk("bp_read_ctrl", read_ctrl, 1'b0);
    chk("bp_tvalid", mif.m_tvalid, 1'b1);
    chk("bp_tdata", mif.m_tdata, expw(32'd9, 0));
    repeat (3) tick();
    chk("bp_stable_tdata", mif.m_tdata, expw(32'd9, 0));
    chk("bp_stable_tlast", mif.m_tlast, 1'b0);
    mif.m_tready = 1'b1;
    wait_done(db, "bp");
    check_words(rb, 32'd9, "bp");

    // Timeout: core never answers.
    resp_on = 1'b0;
    pulse_start(32'd3);
    n = 0;
    while (read_ctrl === 1'b1 && n < 40) begin n++; tick(); end
    chk("to_req_cycles", n, TO);
    chk("to_err", timeout_err, 1'b1);
    chk("to_read_ctrl", read_ctrl, 1'b0);
    chk("to_busy", busy, 1'b1);
    chk("to_tvalid", mif.m_tvalid, 1'b0);
    repeat (2) tick();
    chk("to_err_sticky", timeout_err, 1'b1);
    resp_on = 1'b1; resp_dly = 2; serve = 0;
    rb = rx_q.size(); db = done_cnt;
    pulse_start(32'd5);
    chk("to_restart_err", timeout_err, 1'b0);
    chk("to_restart_rc", read_ctrl, 1'b1);
    wait_done(db, "to_restart");
    check_words(rb, 32'd5, "to_restart");

    // Race: each answer arrives on the last REQ cycle before timeout.
    resp_dly = TO; serve = 0; err_seen = 1'b0;
    rb = rx_q.size(); db = done_cnt;
    pulse_start(32'd11);
    wait_done(db, "race");
    chk("race_no_err", err_seen, 1'b0);
    check_words(rb, 32'd11, "race");

    // Spurious strobes outside REQ, plus a start while busy.
    resp_dly = 2; serve = 0; spur = 1'b1;
    rb = rx_q.size(); db = done_cnt;
    repeat (3) tick();
    chk("spur_idle_busy", busy, 1'b0);
    chk("spur_idle_tvalid", mif.m_tvalid, 1'b0);
    pulse_start(32'd8);
    repeat (4) tick();
    pulse_start(32'd99);
    wait_done(db, "spur");
    spur = 1'b0;
    check_words(rb, 32'd8, "spur");

    // Reset mid-drain after two captures, then a clean drain.
    mif.m_tready = 1'b0;
    serve = 0; caps = 0;
    pulse_start(32'd4);
    n = 0;
    while (caps < 2 && n < 40) begin tick(); n++; end
    tick();
    chk("mid_caps", caps, 2);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_read_ctrl", read_ctrl, 1'b0);
    chk("mid_rst_tvalid", mif.m_tvalid, 1'b0);
    chk("mid_rst_tlast", mif.m_tlast, 1'b0);
    chk("mid_rst_tdata", mif.m_tdata, 256'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", timeout_err, 1'b0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    mif.m_tready = 1'b1;
    serve = 0;
    rb = rx_q.size(); db = done_cnt;
    pulse_start(32'd6);
    wait_done(db, "post_rst");
    check_words(rb, 32'd6, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
